entry_accumulator: RTL and testbench
====================================

ENTRY_ACCUMULATOR -- requirements
Module: entry_accumulator

Interface
REQ-001 Parameter W, default 13, is the bit width of the entry, total and display value.
REQ-002 Parameter MAXVAL, default 9999, is the largest decimal value accepted, capped at 2^W-1.
REQ-003 Clock  input  1  is the single rising-edge clock.
REQ-004 Reset  input  1  is the synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-005 KeyValid  input  1  is a one-cycle strobe that qualifies KeyCode.
REQ-006 KeyCode  input  4  carries the key: 0-9 digit, 10 ADD, 11 TOTAL, 12 CLEAR, 13 VOID, 14-15 ignored.
REQ-007 N  output  W  is the unsigned value for the downstream 7-segment converter.
REQ-008 Total  output  W  is the running sale total.
REQ-009 ItemCount  output  8  is the number of items in the sale.
REQ-010 Mode  output  2  is the state: 00 IDLE, 01 ENTRY, 10 SHOWTOT, 11 ERROR.
REQ-011 Error  output  1  is high only in ERROR.

Function
REQ-012 Every output shall be registered and shall reflect a key on the clock edge after its KeyValid cycle, giving 1-cycle latency.
REQ-013 With KeyValid low, or with KeyCode 14-15, state and outputs shall hold.
REQ-014 N shall equal 0 in IDLE, Entry in ENTRY, Total in SHOWTOT, and 0 in ERROR.
REQ-015 Digit append shall be Entry*10+d computed in W+4 bits; it is accepted only if the result <= MAXVAL, otherwise the digit is dropped and Entry holds.
REQ-016 IDLE transitions:
- digit: Entry=d, go to ENTRY.
- TOTAL: go to SHOWTOT.
- ADD, VOID, CLEAR: ignored.
REQ-017 ENTRY transitions:
- digit: append per REQ-015.
- CLEAR: Entry=0, go to IDLE.
- TOTAL: ignored.
REQ-018 ENTRY with ADD:
- if Total+Entry <= MAXVAL: Total+=Entry, ItemCount+=1 (saturating at 255), Entry=0, go to IDLE.
- otherwise: go to ERROR with Total unchanged.
REQ-019 ENTRY with VOID:
- if Entry <= Total: Total-=Entry, ItemCount-=1 (saturating at 0), Entry=0, go to IDLE.
- otherwise: go to ERROR.
REQ-020 SHOWTOT transitions:
- digit: Entry=d, go to ENTRY (the sale continues).
- CLEAR: Total=0, ItemCount=0, go to IDLE (new sale).
- other keys: ignored.
REQ-021 In ERROR, only CLEAR shall act: Total=0, Entry=0, ItemCount=0, go to IDLE.
REQ-022 The comparison and add/subtract logic shall use W+1 bits so that no wrap-around is possible.
REQ-023 An entry of 0 added with ADD shall count as an item.

Reset
REQ-024 Reset shall take priority over KeyValid on the same edge.
REQ-025 Reset shall apply from any state, including mid-entry, and shall set: state IDLE, Entry=0, Total=0, ItemCount=0, N=0, Mode=00, Error=0.

Structure
REQ-026 A shared package (cash_register_pkg) shall hold the key-code constants, the Mode/state encodings and the default MAXVAL.
REQ-027 One combinational sub-module, digit_append, shall compute Entry*10+d and its fits flag.
REQ-028 The FSM, the accumulators and the output registers shall reside in entry_accumulator.

Verification
REQ-029 Keys 1,2,5 then ADD -> N shows 1, 12, 125, then 0; Total=125, ItemCount=1, Mode=00.
REQ-030 Keys 9,9,9,9,9 with W=14 -> fifth digit dropped, N=9999; with W=13 -> keys 9,9,9 accepted, the fourth 9 dropped, N=999.
REQ-031 Total=8000 (W=13, MAXVAL=8191), enter 500, ADD -> Mode=11, Error=1, N=0; then CLEAR -> Total=0, Mode=00.
REQ-032 Total=125, enter 25, VOID -> Total=100, ItemCount=0; then enter 200, VOID -> ERROR.
REQ-033 ADD 40, TOTAL -> N=40, Mode=10; then digit 3 -> Mode=01, N=3, Total=40.
REQ-034 Reset asserted together with KeyValid=1, KeyCode=ADD while in ENTRY -> next cycle all outputs 0, Mode=00.

Source files
------------

// File: rtl/cash_register_pkg.sv
// Shared key codes, mode encodings and value limits for the cash-register entry path.
package cash_register_pkg;

    localparam int unsigned DEFAULT_MAXVAL = 9999;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_TOTAL     = 4'd11;
    localparam logic [3:0] KEY_CLEAR     = 4'd12;
    localparam logic [3:0] KEY_VOID      = 4'd13;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'b00,
        MODE_ENTRY   = 2'b01,
        MODE_SHOWTOT = 2'b10,
        MODE_ERROR   = 2'b11
    } mode_e;

    // Largest value representable in w bits bounds the usable maximum.
    function automatic int unsigned cap_maxval(input int unsigned w, input int unsigned m);
        longint unsigned lim;
        lim = (64'd1 << w) - 64'd1;
        if (64'(m) > lim) return 32'(lim);
        return m;
    endfunction

endpackage

// File: rtl/entry_accumulator_if.sv
// Key input and display/total outputs of the entry accumulator.
interface entry_accumulator_if #(
    parameter int unsigned W = 13
);
    logic         KeyValid;
    logic [3:0]   KeyCode;
    logic [W-1:0] N;
    logic [W-1:0] Total;
    logic [7:0]   ItemCount;
    logic [1:0]   Mode;
    logic         Error;

    modport master (
        output KeyValid, KeyCode,
        input  N, Total, ItemCount, Mode, Error
    );

    modport slave (
        input  KeyValid, KeyCode,
        output N, Total, ItemCount, Mode, Error
    );
endinterface

// File: rtl/digit_append.sv
// Combinational decimal shift-in: entry*10 + digit, with a flag telling whether it stays within MAXV.
module digit_append #(
    parameter int unsigned W    = 13,
    parameter int unsigned MAXV = 8191
) (
    input  logic [W-1:0] entry,
    input  logic [3:0]   digit,
    output logic [W-1:0] result,
    output logic         fits
);
    localparam int unsigned WA = W + 4;

    logic [WA-1:0] wide;

    // W+4 bits hold (2^W-1)*10+9 without overflow.
    assign wide   = (WA'(entry) * WA'(10)) + WA'(digit);
    assign fits   = (wide <= WA'(MAXV));
    assign result = wide[W-1:0];
endmodule

// File: rtl/entry_accumulator.sv
// Cash-register entry FSM: builds the keyed value, accumulates the sale total and item count.
module entry_accumulator
    import cash_register_pkg::*;
#(
    parameter int unsigned W      = 13,
    parameter int unsigned MAXVAL = DEFAULT_MAXVAL
) (
    input  logic                Clock,
    input  logic                Reset,
    entry_accumulator_if.slave  bus
);
    localparam int unsigned MAXV = cap_maxval(W, MAXVAL);
    localparam int unsigned WS   = W + 1;

    mode_e        state;
    logic [W-1:0] entry;
    logic [W-1:0] total;
    logic [7:0]   count;
    logic [W-1:0] n_q;
    logic         err_q;

    logic [W-1:0]  app_result;
    logic          app_fits;
    logic [WS-1:0] sum;
    logic [WS-1:0] diff;
    logic          is_digit;
    logic [W-1:0]  digit_val;

    digit_append #(.W(W), .MAXV(MAXV)) u_digit_append (
        .entry  (entry),
        .digit  (bus.KeyCode),
        .result (app_result),
        .fits   (app_fits)
    );

    // One guard bit on both paths so overflow and underflow are visible.
    assign sum       = WS'(total) + WS'(entry);
    assign diff      = WS'(total) - WS'(entry);
    assign is_digit  = (bus.KeyCode <= KEY_DIGIT_MAX);
    assign digit_val = W'(bus.KeyCode);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= MODE_IDLE;
            entry <= '0;
            total <= '0;
            count <= '0;
            n_q   <= '0;
            err_q <= 1'b0;
        end else if (bus.KeyValid) begin
            case (state)
                MODE_IDLE: begin
                    if (is_digit) begin
                        entry <= digit_val;
                        n_q   <= digit_val;
                        state <= MODE_ENTRY;
                    end else if (bus.KeyCode == KEY_TOTAL) begin
                        n_q   <= total;
                        state <= MODE_SHOWTOT;
                    end
                end
                MODE_ENTRY: begin
                    if (is_digit) begin
                        if (app_fits) begin
                            entry <= app_result;
                            n_q   <= app_result;
                        end
                    end else if (bus.KeyCode == KEY_CLEAR) begin
                        entry <= '0;
                        n_q   <= '0;
                        state <= MODE_IDLE;
                    end else if (bus.KeyCode == KEY_ADD) begin
                        n_q <= '0;
                        if (sum <= WS'(MAXV)) begin
                            total <= sum[W-1:0];
                            if (count != 8'hFF) count <= count + 8'd1;
                            entry <= '0;
                            state <= MODE_IDLE;
                        end else begin
                            state <= MODE_ERROR;
                            err_q <= 1'b1;
                        end
                    end else if (bus.KeyCode == KEY_VOID) begin
                        n_q <= '0;
                        if (!diff[W]) begin
                            total <= diff[W-1:0];
                            if (count != 8'h00) count <= count - 8'd1;
                            entry <= '0;
                            state <= MODE_IDLE;
                        end else begin
                            state <= MODE_ERROR;
                            err_q <= 1'b1;
                        end
                    end
                end
                MODE_SHOWTOT: begin
                    if (is_digit) begin
                        entry <= digit_val;
                        n_q   <= digit_val;
                        state <= MODE_ENTRY;
                    end else if (bus.KeyCode == KEY_CLEAR) begin
                        total <= '0;
                        count <= '0;
                        n_q   <= '0;
                        state <= MODE_IDLE;
                    end
                end
                MODE_ERROR: begin
                    if (bus.KeyCode == KEY_CLEAR) begin
                        total <= '0;
                        entry <= '0;
                        count <= '0;
                        n_q   <= '0;
                        err_q <= 1'b0;
                        state <= MODE_IDLE;
                    end
                end
                default: state <= MODE_IDLE;
            endcase
        end
    end

    assign bus.N         = n_q;
    assign bus.Total     = total;
    assign bus.ItemCount = count;
    assign bus.Mode      = state;
    assign bus.Error     = err_q;
endmodule

// File: tb/tb_entry_accumulator.sv
// Directed bench for entry_accumulator: a W=13 instance (cap 8191) and a W=14 instance (MAXVAL 9999).
module tb_entry_accumulator;

    logic Clock;
    logic Reset;
    int   compared;
    int   mismatched;

    entry_accumulator_if #(.W(13)) bus13 ();
    entry_accumulator_if #(.W(14)) bus14 ();

    entry_accumulator #(.W(13), .MAXVAL(9999)) dut13 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus13.slave)
    );

    entry_accumulator #(.W(14), .MAXVAL(9999)) dut14 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus14.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one key on both instances for one cycle; outputs are sampled at the following negedge.
    task automatic press(input logic [3:0] code);
        bus13.KeyValid = 1'b1; bus13.KeyCode = code;
        bus14.KeyValid = 1'b1; bus14.KeyCode = code;
        @(negedge Clock);
        bus13.KeyValid = 1'b0; bus13.KeyCode = 4'd0;
        bus14.KeyValid = 1'b0; bus14.KeyCode = 4'd0;
    endtask

    task automatic check13(input string tag, input int n, input int tot, input int cnt,
                           input int mode, input int err);
        check({tag, ".N"},     32'(bus13.N),         32'(n));
        check({tag, ".Total"}, 32'(bus13.Total),     32'(tot));
        check({tag, ".Count"}, 32'(bus13.ItemCount), 32'(cnt));
        check({tag, ".Mode"},  32'(bus13.Mode),      32'(mode));
        check({tag, ".Error"}, 32'(bus13.Error),     32'(err));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        Reset = 1'b1;
        bus13.KeyValid = 1'b0; bus13.KeyCode = 4'd0;
        bus14.KeyValid = 1'b0; bus14.KeyCode = 4'd0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check13("reset", 0, 0, 0, 0, 0);
        repeat (3) @(negedge Clock);
        check13("idle_hold", 0, 0, 0, 0, 0);

        // 1,2,5 ADD
        press(4'd1);  check13("k1", 1, 0, 0, 1, 0);
        press(4'd2);  check13("k12", 12, 0, 0, 1, 0);
        press(4'd5);  check13("k125", 125, 0, 0, 1, 0);
        press(4'd10); check13("add125", 0, 125, 1, 0, 0);

        // 25 VOID, then 200 VOID overdraws
        press(4'd2); press(4'd5);
        check13("e25", 25, 125, 1, 1, 0);
        press(4'd13); check13("void25", 0, 100, 0, 0, 0);
        press(4'd2); press(4'd0); press(4'd0);
        check13("e200", 200, 100, 0, 1, 0);
        press(4'd13); check13("void200_err", 0, 100, 0, 3, 1);
        press(4'd5);  check13("err_ignore_digit", 0, 100, 0, 3, 1);
        press(4'd12); check13("err_clear", 0, 0, 0, 0, 0);

        // ADD 40, TOTAL, digit 3 continues the sale
        press(4'd4); press(4'd0); press(4'd10);
        check13("add40", 0, 40, 1, 0, 0);
        press(4'd11); check13("showtot40", 40, 40, 1, 2, 0);
        press(4'd10); check13("showtot_ignore_add", 40, 40, 1, 2, 0);
        press(4'd3);  check13("showtot_digit", 3, 40, 1, 1, 0);
        press(4'd14); check13("key14_hold", 3, 40, 1, 1, 0);
        press(4'd11); check13("entry_total_ignored", 3, 40, 1, 1, 0);
        press(4'd12); check13("entry_clear", 0, 40, 1, 0, 0);
        press(4'd13); check13("idle_void_ignored", 0, 40, 1, 0, 0);
        press(4'd11); check13("showtot_again", 40, 40, 1, 2, 0);
        press(4'd12); check13("showtot_clear", 0, 0, 0, 0, 0);

        // Total 8000, then 500 ADD overflows the W=13 cap of 8191
        press(4'd8); press(4'd0); press(4'd0); press(4'd0); press(4'd10);
        check13("add8000", 0, 8000, 1, 0, 0);
        press(4'd5); press(4'd0); press(4'd0);
        check13("e500", 500, 8000, 1, 1, 0);
        press(4'd10); check13("add500_err", 0, 8000, 1, 3, 1);
        check("w14_add500_total", 32'(bus14.Total), 32'd8500);
        press(4'd12); check13("err_clear2", 0, 0, 0, 0, 0);

        // Five nines: W=13 keeps 999, W=14 keeps 9999
        press(4'd9); check13("n9", 9, 0, 0, 1, 0);
        check("w14_n9", 32'(bus14.N), 32'd9);
        press(4'd9); check13("n99", 99, 0, 0, 1, 0);
        press(4'd9); check13("n999", 999, 0, 0, 1, 0);
        check("w14_n999", 32'(bus14.N), 32'd999);
        press(4'd9); check13("n9999_drop", 999, 0, 0, 1, 0);
        check("w14_n9999", 32'(bus14.N), 32'd9999);
        press(4'd9); check13("n99999_drop", 999, 0, 0, 1, 0);
        check("w14_n99999_drop", 32'(bus14.N), 32'd9999);
        check("w14_mode_entry", 32'(bus14.Mode), 32'd1);
        press(4'd12); check13("nines_clear", 0, 0, 0, 0, 0);

        // Exact fit at 8191, zero-value item, exact void
        press(4'd8); press(4'd1); press(4'd9); press(4'd1);
        check13("e8191", 8191, 0, 0, 1, 0);
        press(4'd10); check13("add8191", 0, 8191, 1, 0, 0);
        press(4'd0);  check13("e0", 0, 8191, 1, 1, 0);
        press(4'd10); check13("add0_counts", 0, 8191, 2, 0, 0);
        press(4'd8); press(4'd1); press(4'd9); press(4'd1);
        press(4'd13); check13("void8191", 0, 0, 1, 0, 0);

        // Reset wins over a same-edge ADD while in ENTRY
        press(4'd3); check13("pre_reset_entry", 3, 0, 1, 1, 0);
        Reset = 1'b1;
        bus13.KeyValid = 1'b1; bus13.KeyCode = 4'd10;
        bus14.KeyValid = 1'b1; bus14.KeyCode = 4'd10;
        @(negedge Clock);
        Reset = 1'b0;
        bus13.KeyValid = 1'b0; bus14.KeyValid = 1'b0;
        check13("reset_vs_add", 0, 0, 0, 0, 0);
        check("w14_reset_total", 32'(bus14.Total), 32'd0);
        check("w14_reset_mode",  32'(bus14.Mode),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
